// File: rtl/wr_port_arbiter.sv
// wr_port_arbiter
//   Round-robin arbiter that shares one register-file write port among four
//   writeback sources. A grant lasts until the grantee aborts (drops its
//   request), signals its final cycle with last, or reaches MAX_HOLD cycles.
//   On release the next requester is picked starting just after the releasing
//   source, with no idle bubble.
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   req[3:0]     in   per-source request, held for the whole transaction
//   last         in   grantee's final cycle, only looked at while granted
//   grant[3:0]   out  one-hot grant, zero when no grant is active
//   grant_idx    out  index of current grantee, 0 when idle
//   grant_valid  out  a grant is active this cycle
//   timeout      out  this cycle is the forced-final cycle of the grant
//
// state   | meaning
// S_IDLE  | no grant active, waiting for any request
// S_GRANT | grant_idx owns the write port, hold_q counts cycles held

module wr_port_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       last,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    idx_q, idx_d;
    logic          valid_q, valid_d;
    logic [HW-1:0] hold_q, hold_d;

    logic          hold_at_max;
    logic          release_now;

    // First requester in rotation order p, p+1, p+2, p+3. Scanning from the
    // farthest offset down lets the nearest requester overwrite the others.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] sel;
        logic [1:0] cand;
        sel = p;
        for (int k = 3; k >= 0; k--) begin
            cand = p + 2'(k);
            if (r[cand]) sel = cand;
        end
        return sel;
    endfunction

    assign hold_at_max = (hold_q == HOLD_MAX);
    assign release_now = ~req[idx_q] | last | hold_at_max;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_GRANT;
                    idx_d   = pick(req, ptr_q);
                    valid_d = 1'b1;
                    hold_d  = '0;
                end
            end
            S_GRANT: begin
                if (release_now) begin
                    // Releasing source drops to lowest priority.
                    ptr_d = idx_q + 2'd1;
                    if (|req) begin
                        idx_d  = pick(req, idx_q + 2'd1);
                        hold_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        idx_d   = 2'd0;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        grant       = valid_q ? (4'b0001 << idx_q) : 4'b0000;
        grant_idx   = idx_q;
        grant_valid = valid_q;
        // A coincident last ends the grant normally, so it is not a timeout.
        timeout     = valid_q & hold_at_max & ~last;
    end

endmodule
